// File: rtl/dual_port_ram_arbiter.sv
// ---------------------------------------------------------------------------
// dual_port_ram_arbiter
//
// Front end for the register-file RAM (an external dual_port_ram). It shares
// the RAM's single write port between two requesters, A and B, using
// round-robin arbitration. It also sequences the synchronous read port.
//
// Optional feature: define DUAL_PORT_RAM_ARB_FWD_EN to forward write data to
// a read of the same address in the same cycle, which gives write-first
// results. Without the macro, a colliding read returns the RAM's old data.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   wr_req_x/wr_addr_x/wr_data_x     write request from A/B; held until acked
//   wr_ack_x                         combinational grant, write commits now
//   rd_req, rd_addr                  read strobe and address
//   rd_data, rd_valid                read result one cycle after rd_req
//   ram_waddr/ram_raddr/ram_din      to the RAM
//   ram_write_en                     to the RAM
//   ram_dout                         from the RAM (registered read, old data
//                                    on a same-address collision)
// ---------------------------------------------------------------------------
module dual_port_ram_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 33
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_req_a,
   input  logic [ADDR_WIDTH-1:0] wr_addr_a,
   input  logic [DATA_WIDTH-1:0] wr_data_a,
   output logic                  wr_ack_a,
   input  logic                  wr_req_b,
   input  logic [ADDR_WIDTH-1:0] wr_addr_b,
   input  logic [DATA_WIDTH-1:0] wr_data_b,
   output logic                  wr_ack_b,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_write_en,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   // last_b = 1 means B received the most recent grant. Reset to B so that
   // A wins the first contention.
   logic last_b;
   logic grant_a, grant_b;

   // Under contention, the requester that was not granted last wins.
   assign grant_a = wr_req_a & (~wr_req_b | last_b);
   assign grant_b = wr_req_b & (~wr_req_a | ~last_b);

   assign wr_ack_a     = grant_a;
   assign wr_ack_b     = grant_b;
   assign ram_write_en = grant_a | grant_b;
   // With no grant, the address and data come from A. They are don't-care
   // because write_en is low.
   assign ram_waddr    = grant_b ? wr_addr_b : wr_addr_a;
   assign ram_din      = grant_b ? wr_data_b : wr_data_a;
   assign ram_raddr    = rd_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last_b <= 1'b1;
      else if (grant_a | grant_b)
         last_b <= grant_b;
   end

   // rd_primed keeps rd_data at 0 after reset until the first valid read.
   // Before that, the RAM output is uninitialised.
   logic rd_primed;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid  <= 1'b0;
         rd_primed <= 1'b0;
      end else begin
         rd_valid  <= rd_req;
         if (rd_valid)
            rd_primed <= 1'b1;
      end
   end

   logic [DATA_WIDTH-1:0] rd_mux;

`ifdef DUAL_PORT_RAM_ARB_FWD_EN
   // Capture the granted write when it hits the address being read. On the
   // next cycle, the captured data replaces the RAM's old data.
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_hit  <= 1'b0;
         fwd_data <= '0;
      end else begin
         fwd_hit <= rd_req & ram_write_en & (rd_addr == ram_waddr);
         if (rd_req & ram_write_en & (rd_addr == ram_waddr))
            fwd_data <= ram_din;
      end
   end

   assign rd_mux = fwd_hit ? fwd_data : ram_dout;
`else
   assign rd_mux = ram_dout;
`endif

   assign rd_data = (rd_valid | rd_primed) ? rd_mux : '0;

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
module tb_dual_port_ram_arbiter;
   localparam int AW = 5;
   localparam int DW = 33;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_req_a, wr_req_b, rd_req;
   logic [AW-1:0] wr_addr_a, wr_addr_b, rd_addr;
   logic [DW-1:0] wr_data_a, wr_data_b;
   logic          wr_ack_a, wr_ack_b, rd_valid, ram_write_en;
   logic [DW-1:0] rd_data, ram_din, ram_dout;
   logic [AW-1:0] ram_waddr, ram_raddr;

   int n_checks = 0;
   int n_fail   = 0;

   dual_port_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .wr_req_a(wr_req_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a), .wr_ack_a(wr_ack_a),
      .wr_req_b(wr_req_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b), .wr_ack_b(wr_ack_b),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_din(ram_din),
      .ram_write_en(ram_write_en), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Behavioural dual-port RAM: registered read that returns old data on a
   // same-address collision.
   logic [DW-1:0] mem [0:31];
   always @(posedge clk) begin
      if (ram_write_en) mem[ram_waddr] <= ram_din;
      ram_dout <= mem[ram_raddr];
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_req_a = 0; wr_req_b = 0; rd_req = 0;
      wr_addr_a = '0; wr_addr_b = '0; rd_addr = '0;
      wr_data_a = '0; wr_data_b = '0;
   endtask

   task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_req_a = 1; wr_addr_a = a; wr_data_a = d;
      #1;
      n_checks++;
      if (wr_ack_a !== 1'b1) begin
         n_fail++; $display("FAIL write_a_ack: got %b expected 1", wr_ack_a);
      end
      tick();
      wr_req_a = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({rd_valid, ram_write_en, wr_ack_a, wr_ack_b} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_hold: got %b expected 0000",
                               {rd_valid, ram_write_en, wr_ack_a, wr_ack_b});
         end
      end
      reset_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({rd_valid, ram_write_en, wr_ack_a, wr_ack_b} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_idle: got %b expected 0000",
                               {rd_valid, ram_write_en, wr_ack_a, wr_ack_b});
         end
      end
      n_checks++;
      if (rd_data !== '0) begin
         n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp_ack [4];
      exp_ack[0] = 2'b10; exp_ack[1] = 2'b01; exp_ack[2] = 2'b10; exp_ack[3] = 2'b01;
      wr_req_a = 1; wr_addr_a = 5'd5; wr_data_a = 33'hA;
      wr_req_b = 1; wr_addr_b = 5'd6; wr_data_b = 33'hB;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if ({wr_ack_a, wr_ack_b} !== exp_ack[i]) begin
            n_fail++; $display("FAIL contention_grant%0d: got %b expected %b",
                               i, {wr_ack_a, wr_ack_b}, exp_ack[i]);
         end
         n_checks++;
         if (ram_waddr !== (exp_ack[i][1] ? 5'd5 : 5'd6) || ram_write_en !== 1'b1) begin
            n_fail++; $display("FAIL contention_waddr%0d: got %0d/%b expected %0d/1",
                               i, ram_waddr, ram_write_en, exp_ack[i][1] ? 5 : 6);
         end
         tick();
      end
      wr_req_a = 0; wr_req_b = 0;
      rd_req = 1; rd_addr = 5'd5;
      tick();
      rd_addr = 5'd6;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 33'hA) begin
         n_fail++; $display("FAIL contention_rd5: got %b/%h expected 1/%h", rd_valid, rd_data, 33'hA);
      end
      tick();
      rd_req = 0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 33'hB) begin
         n_fail++; $display("FAIL contention_rd6: got %b/%h expected 1/%h", rd_valid, rd_data, 33'hB);
      end
      tick();
   endtask

   task automatic test_single_write();
      wr_req_a = 1; wr_addr_a = 5'd3; wr_data_a = 33'h1_2345_6789;
      #1;
      n_checks++;
      if (wr_ack_a !== 1'b1 || wr_ack_b !== 1'b0 || ram_write_en !== 1'b1 ||
          ram_waddr !== 5'd3 || ram_din !== 33'h1_2345_6789) begin
         n_fail++; $display("FAIL single_grant: got ack=%b%b we=%b wa=%0d din=%h expected 10/1/3/123456789",
                            wr_ack_a, wr_ack_b, ram_write_en, ram_waddr, ram_din);
      end
      tick();
      wr_req_a = 0;
      rd_req = 1; rd_addr = 5'd3;
      #1;
      n_checks++;
      if (wr_ack_a !== 1'b0 || ram_write_en !== 1'b0 || ram_raddr !== 5'd3) begin
         n_fail++; $display("FAIL single_ack_drop: got ack=%b we=%b ra=%0d expected 0/0/3",
                            wr_ack_a, ram_write_en, ram_raddr);
      end
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_rd_latency: got %b expected 0", rd_valid);
      end
      tick();
      rd_req = 0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 33'h1_2345_6789) begin
         n_fail++; $display("FAIL single_rd: got %b/%h expected 1/123456789", rd_valid, rd_data);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_rd_valid_drop: got %b expected 0", rd_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp [3];
      exp[0] = 33'h11; exp[1] = 33'h22; exp[2] = 33'h33;
      for (int i = 0; i < 3; i++) write_a(AW'(i + 1), exp[i]);
      rd_req = 1; rd_addr = 5'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) rd_addr = AW'(i + 2);
         else rd_req = 0;
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
            n_fail++; $display("FAIL b2b_rd%0d: got %b/%h expected 1/%h", i, rd_valid, rd_data, exp[i]);
         end
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_valid_drop: got %b expected 0", rd_valid);
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] exp_coll;
`ifdef DUAL_PORT_RAM_ARB_FWD_EN
      exp_coll = 33'h1_FFFF_FFFF;
`else
      exp_coll = 33'h0_0000_0070;
`endif
      write_a(5'd7, 33'h0_0000_0070);
      wr_req_a = 1; wr_addr_a = 5'd7; wr_data_a = 33'h1_FFFF_FFFF;
      rd_req = 1; rd_addr = 5'd7;
      #1;
      n_checks++;
      if (wr_ack_a !== 1'b1) begin
         n_fail++; $display("FAIL coll_ack: got %b expected 1", wr_ack_a);
      end
      tick();
      wr_req_a = 0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_coll) begin
         n_fail++; $display("FAIL coll_rd: got %b/%h expected 1/%h", rd_valid, rd_data, exp_coll);
      end
      tick();
      rd_req = 0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 33'h1_FFFF_FFFF) begin
         n_fail++; $display("FAIL coll_rd_after: got %b/%h expected 1/1ffffffff", rd_valid, rd_data);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      rd_req = 1; rd_addr = 5'd3;
      tick();
      rd_req = 0;
      reset_n = 0;
      #1;
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_valid: got %b expected 0", rd_valid);
      end
      tick(); tick();
      reset_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle%0d: got %b expected 0", i, rd_valid);
         end
      end
      wr_req_a = 1; wr_addr_a = 5'd9; wr_data_a = 33'h9;
      wr_req_b = 1; wr_addr_b = 5'd10; wr_data_b = 33'h10;
      #1;
      n_checks++;
      if ({wr_ack_a, wr_ack_b} !== 2'b10) begin
         n_fail++; $display("FAIL midrst_first_grant: got %b expected 10", {wr_ack_a, wr_ack_b});
      end
      tick();
      wr_req_a = 0; wr_req_b = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_write();
      test_back_to_back();
      test_collision();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
